// File: rtl/branch_predict_unit.sv
// Execute-stage branch resolution with a direct-mapped BHT/BTN predictor and halt latch.
// Optional statistics counters are enabled by defining BRANCH_PREDICT_STATS_EN.
module branch_predict_unit #(
  parameter int PC_W      = 9,
  parameter int BHT_DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PC_W-1:0]  Fetch_PC,
  output logic             Pred_Taken,
  output logic [31:0]      Pred_Target,
  input  logic             Valid_EX,
  input  logic             Stall,
  input  logic [PC_W-1:0]  Cur_PC,
  input  logic [31:0]      Imm,
  input  logic             Branch,
  input  logic             JalPrima,
  input  logic             JalrSel,
  input  logic             Halt,
  input  logic [31:0]      AluResult,
  input  logic             Pred_Taken_EX,
  input  logic [31:0]      Pred_Target_EX,
  output logic [31:0]      PC_Imm,
  output logic [31:0]      PC_Four,
  output logic [31:0]      BrPC,
  output logic             PcSel,
  output logic             Mispredict,
  output logic             Halted,
  output logic [31:0]      Br_Count,
  output logic [31:0]      Mispred_Count
);

  localparam int IDX_W = $clog2(BHT_DEPTH);
  localparam int TAG_W = PC_W - IDX_W - 2;
  // Zero-width tags are carried as a constant 1-bit field that always matches
  localparam int TAG_S = (TAG_W > 0) ? TAG_W : 1;

  typedef enum logic {S_RUN, S_HALTED} state_t;

  state_t             state_q;
  logic [31:0]        halt_pc_q;
  logic [1:0]         cnt_q    [BHT_DEPTH];
  logic               valid_q  [BHT_DEPTH];
  logic [TAG_S-1:0]   tag_q    [BHT_DEPTH];
  logic [31:0]        target_q [BHT_DEPTH];

  logic [IDX_W-1:0]   f_idx, x_idx;
  logic [TAG_S-1:0]   f_tag, x_tag;
  logic               f_hit, x_hit;
  logic [31:0]        fetch_pc32, cur_pc32;
  logic               is_ctl, act_taken, halt_now, upd_en;
  logic [31:0]        act_target;
  logic [1:0]         cnt_d;

  assign f_idx = Fetch_PC[IDX_W+1:2];
  assign x_idx = Cur_PC[IDX_W+1:2];

  generate
    if (TAG_W > 0) begin : g_tag
      assign f_tag = Fetch_PC[PC_W-1:IDX_W+2];
      assign x_tag = Cur_PC[PC_W-1:IDX_W+2];
    end else begin : g_notag
      assign f_tag = '0;
      assign x_tag = '0;
    end
  endgenerate

  assign fetch_pc32  = 32'(Fetch_PC);
  assign cur_pc32    = 32'(Cur_PC);

  // Fetch-side lookup sees the pre-write table contents
  assign f_hit       = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign Pred_Taken  = f_hit && cnt_q[f_idx][1];
  assign Pred_Target = Pred_Taken ? target_q[f_idx] : fetch_pc32 + 32'd4;

  assign PC_Imm     = cur_pc32 + Imm;
  assign PC_Four    = cur_pc32 + 32'd4;
  assign is_ctl     = Branch || JalPrima || JalrSel;
  assign act_taken  = (Branch && AluResult[0]) || JalPrima || JalrSel;
  assign act_target = (JalrSel && !JalPrima && !Branch) ? AluResult : PC_Imm;
  assign Halted     = (state_q == S_HALTED);
  assign halt_now   = Valid_EX && Halt;

  assign Mispredict = Valid_EX && !Halt && !Halted &&
                      ((act_taken != Pred_Taken_EX) ||
                       (act_taken && (act_target != Pred_Target_EX)));

  assign PcSel  = Halted || halt_now || Mispredict;
  assign upd_en = Valid_EX && is_ctl && !Stall && !Halted;

  always_comb begin
    BrPC = 32'd0;
    if (Halted)                       BrPC = halt_pc_q;
    else if (halt_now)                BrPC = cur_pc32;
    else if (Mispredict && act_taken) BrPC = act_target;
    else if (Mispredict)              BrPC = PC_Four;
  end

  assign x_hit = valid_q[x_idx] && (tag_q[x_idx] == x_tag);

  always_comb begin
    cnt_d = cnt_q[x_idx];
    if (act_taken && !x_hit)                      cnt_d = 2'd2;
    else if (act_taken && cnt_q[x_idx] != 2'd3)   cnt_d = cnt_q[x_idx] + 2'd1;
    else if (!act_taken && cnt_q[x_idx] != 2'd0)  cnt_d = cnt_q[x_idx] - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_RUN;
      halt_pc_q <= 32'd0;
      for (int i = 0; i < BHT_DEPTH; i++) begin
        cnt_q[i]    <= 2'd1;
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= 32'd0;
      end
    end else begin
      if (upd_en) begin
        cnt_q[x_idx] <= cnt_d;
        if (act_taken) begin
          valid_q[x_idx]  <= 1'b1;
          tag_q[x_idx]    <= x_tag;
          target_q[x_idx] <= act_target;
        end
      end
      case (state_q)
        S_RUN: begin
          if (halt_now && !Stall) begin
            state_q   <= S_HALTED;
            halt_pc_q <= cur_pc32;
          end
        end
        default: state_q <= S_HALTED;
      endcase
    end
  end

`ifdef BRANCH_PREDICT_STATS_EN
  logic [31:0] br_cnt_q, mp_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      br_cnt_q <= 32'd0;
      mp_cnt_q <= 32'd0;
    end else if (upd_en) begin
      if (br_cnt_q != 32'hFFFF_FFFF) br_cnt_q <= br_cnt_q + 32'd1;
      if (Mispredict && mp_cnt_q != 32'hFFFF_FFFF) mp_cnt_q <= mp_cnt_q + 32'd1;
    end
  end

  assign Br_Count      = br_cnt_q;
  assign Mispred_Count = mp_cnt_q;
`else
  assign Br_Count      = 32'd0;
  assign Mispred_Count = 32'd0;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed + randomized bench for branch_predict_unit against a table-level reference model.
module tb_branch_predict_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [8:0]  Fetch_PC, Cur_PC;
  logic        Pred_Taken, Valid_EX, Stall, Branch, JalPrima, JalrSel, Halt, Pred_Taken_EX;
  logic [31:0] Pred_Target, Imm, AluResult, Pred_Target_EX;
  logic [31:0] PC_Imm, PC_Four, BrPC, Br_Count, Mispred_Count;
  logic        PcSel, Mispredict, Halted;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int unsigned m_cnt [16];
  bit          m_val [16];
  int unsigned m_tag [16];
  logic [31:0] m_tgt [16];
  bit          m_halted;
  logic [31:0] m_hpc, m_br, m_mp;

  branch_predict_unit #(.PC_W(9), .BHT_DEPTH(16)) dut (
    .clk(clk), .reset(reset), .Fetch_PC(Fetch_PC), .Pred_Taken(Pred_Taken),
    .Pred_Target(Pred_Target), .Valid_EX(Valid_EX), .Stall(Stall), .Cur_PC(Cur_PC),
    .Imm(Imm), .Branch(Branch), .JalPrima(JalPrima), .JalrSel(JalrSel), .Halt(Halt),
    .AluResult(AluResult), .Pred_Taken_EX(Pred_Taken_EX), .Pred_Target_EX(Pred_Target_EX),
    .PC_Imm(PC_Imm), .PC_Four(PC_Four), .BrPC(BrPC), .PcSel(PcSel),
    .Mispredict(Mispredict), .Halted(Halted), .Br_Count(Br_Count),
    .Mispred_Count(Mispred_Count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) begin
      m_cnt[i] = 1; m_val[i] = 0; m_tag[i] = 0; m_tgt[i] = 32'd0;
    end
    m_halted = 0; m_hpc = 32'd0; m_br = 32'd0; m_mp = 32'd0;
  endfunction

  task automatic do_reset();
    reset = 1'b1; Valid_EX = 0; Stall = 0; Branch = 0; JalPrima = 0; JalrSel = 0; Halt = 0;
    @(posedge clk);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One cycle: drive at negedge, check combinational outputs, update model at posedge
  task automatic step(input logic [8:0] fpc, input logic v, input logic st,
                      input logic [8:0] cpc, input logic [31:0] imm,
                      input logic br, input logic jal, input logic jalr, input logic hlt,
                      input logic [31:0] alu, input logic pte, input logic [31:0] ptt);
    int unsigned fi, xi;
    bit hit, xhit, ept, at, mis, pcs;
    logic [31:0] cur, pci, pc4, eptg, atg, ebr;
    Fetch_PC = fpc; Valid_EX = v; Stall = st; Cur_PC = cpc; Imm = imm;
    Branch = br; JalPrima = jal; JalrSel = jalr; Halt = hlt; AluResult = alu;
    Pred_Taken_EX = pte; Pred_Target_EX = ptt;
    #1;
    cur  = 32'(cpc);
    pci  = cur + imm;
    pc4  = cur + 32'd4;
    fi   = (int'(fpc) / 4) % 16;
    hit  = m_val[fi] && (m_tag[fi] == int'(fpc) / 64);
    ept  = hit && (m_cnt[fi] >= 2);
    eptg = ept ? m_tgt[fi] : 32'(fpc) + 32'd4;
    at   = (br && alu[0]) || jal || jalr;
    atg  = (jalr && !jal && !br) ? alu : pci;
    mis  = v && !hlt && !m_halted && ((at != pte) || (at && atg != ptt));
    if (m_halted)       ebr = m_hpc;
    else if (v && hlt)  ebr = cur;
    else if (mis && at) ebr = atg;
    else if (mis)       ebr = pc4;
    else                ebr = 32'd0;
    pcs = m_halted || (v && hlt) || mis;
    chk("pc_imm", PC_Imm, pci);
    chk("pc_four", PC_Four, pc4);
    chk("pred_taken", 32'(Pred_Taken), 32'(ept));
    chk("pred_target", Pred_Target, eptg);
    chk("mispredict", 32'(Mispredict), 32'(mis));
    chk("pcsel", 32'(PcSel), 32'(pcs));
    chk("brpc", BrPC, ebr);
    chk("halted", 32'(Halted), 32'(m_halted));
`ifdef BRANCH_PREDICT_STATS_EN
    chk("br_count", Br_Count, m_br);
    chk("mispred_count", Mispred_Count, m_mp);
`else
    chk("br_count", Br_Count, 32'd0);
    chk("mispred_count", Mispred_Count, 32'd0);
`endif
    @(posedge clk);
    if (!st && !m_halted) begin
      if (v && (br || jal || jalr)) begin
        xi   = (int'(cpc) / 4) % 16;
        xhit = m_val[xi] && (m_tag[xi] == int'(cpc) / 64);
        if (at) begin
          m_cnt[xi] = !xhit ? 2 : (m_cnt[xi] == 3 ? 3 : m_cnt[xi] + 1);
          m_val[xi] = 1; m_tag[xi] = int'(cpc) / 64; m_tgt[xi] = atg;
        end else if (m_cnt[xi] > 0) begin
          m_cnt[xi] = m_cnt[xi] - 1;
        end
        if (m_br != 32'hFFFF_FFFF) m_br = m_br + 1;
        if (mis && m_mp != 32'hFFFF_FFFF) m_mp = m_mp + 1;
      end
      if (v && hlt) begin
        m_halted = 1; m_hpc = cur;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    Fetch_PC = 0; Cur_PC = 0; Imm = 0; AluResult = 0; Pred_Taken_EX = 0; Pred_Target_EX = 0;
    do_reset();
    // Cold table: no prediction
    step(9'h010, 0, 0, 9'h000, 0, 0, 0, 0, 0, 0, 0, 0);
    // Taken branch allocates weakly-taken entry
    step(9'h020, 1, 0, 9'h020, 32'h40, 1, 0, 0, 0, 32'd1, 0, 0);
    step(9'h020, 0, 0, 9'h000, 0, 0, 0, 0, 0, 0, 0, 0);
    // Not-taken twice: 2 -> 1 -> 0
    step(9'h020, 1, 0, 9'h020, 32'h40, 1, 0, 0, 0, 32'd0, 1, 32'h60);
    step(9'h020, 1, 0, 9'h020, 32'h40, 1, 0, 0, 0, 32'd0, 0, 0);
    step(9'h020, 0, 0, 9'h000, 0, 0, 0, 0, 0, 0, 0, 0);
    // JALR target mismatch
    step(9'h040, 1, 0, 9'h040, 0, 0, 0, 1, 0, 32'h88, 1, 32'h84);
    step(9'h040, 0, 0, 9'h000, 0, 0, 0, 0, 0, 0, 0, 0);
    // Stalled branch must not update
    step(9'h080, 1, 1, 9'h080, 32'h10, 1, 0, 0, 0, 32'd1, 0, 0);
    step(9'h080, 0, 0, 9'h000, 0, 0, 0, 0, 0, 0, 0, 0);
    // Tag conflict: 0x0A0 and 0x0E0 share an index with different tags
    step(9'h0A0, 1, 0, 9'h0A0, 32'h20, 0, 1, 0, 0, 0, 0, 0);
    step(9'h0E0, 1, 0, 9'h0E0, 32'h8, 0, 1, 0, 0, 0, 0, 0);
    step(9'h0A0, 0, 0, 9'h000, 0, 0, 0, 0, 0, 0, 0, 0);
    step(9'h0E0, 0, 0, 9'h000, 0, 0, 0, 0, 0, 0, 0, 0);
    // Halt then attempted branches
    step(9'h030, 1, 0, 9'h030, 0, 0, 0, 0, 1, 0, 0, 0);
    step(9'h020, 1, 0, 9'h020, 32'h40, 1, 0, 0, 0, 32'd1, 0, 0);
    step(9'h020, 1, 0, 9'h020, 32'h40, 1, 0, 0, 0, 32'd1, 0, 0);
    do_reset();
    step(9'h020, 0, 0, 9'h000, 0, 0, 0, 0, 0, 0, 0, 0);
    // Statistics: three events, two mispredicted, one stalled event ignored
    step(9'h000, 1, 0, 9'h100, 32'h4, 1, 0, 0, 0, 32'd1, 0, 0);
    step(9'h000, 1, 0, 9'h104, 32'h4, 1, 0, 0, 0, 32'd0, 0, 0);
    step(9'h000, 1, 1, 9'h108, 32'h4, 1, 0, 0, 0, 32'd1, 0, 0);
    step(9'h000, 1, 0, 9'h10C, 0, 0, 0, 1, 0, 32'h50, 1, 32'h54);
    step(9'h000, 0, 0, 9'h000, 0, 0, 0, 0, 0, 0, 0, 0);
    // Randomized traffic over a small PC pool to provoke hits and conflicts
    for (int i = 0; i < 600; i++) begin
      logic [8:0] fpc, cpc;
      logic [31:0] alu, ptt;
      int kind;
      if (i % 150 == 0) do_reset();
      fpc  = 9'($urandom_range(0, 127) * 4);
      cpc  = ($urandom_range(0, 3) == 0) ? fpc : 9'($urandom_range(0, 127) * 4);
      kind = $urandom_range(0, 9);
      alu  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 1)) : $urandom;
      ptt  = ($urandom_range(0, 1) == 0) ? 32'(cpc) + 32'h40 : 32'($urandom_range(0, 511));
      step(fpc, 1'($urandom_range(0, 5) != 0), 1'($urandom_range(0, 7) == 0), cpc,
           ($urandom_range(0, 1) == 0) ? 32'h40 : $urandom,
           1'(kind < 5), 1'(kind == 5 || kind == 9), 1'(kind >= 6),
           1'($urandom_range(0, 59) == 0), alu, 1'($urandom_range(0, 1)), ptt);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_predict_unit.md
# branch_predict_unit

Execute-stage branch resolution unit with an integrated fetch-side predictor. It computes PC+Imm / PC+4 targets and resolves conditional branches, JAL, JALR and HALT like the current branch logic, and adds a direct-mapped branch history table (2-bit saturating counters) plus branch target buffer. It flags mispredictions against the prediction carried down the pipeline and latches a halt state. Fetch queries it combinationally; execute updates it on the clock edge.

## Interface
- PC_W, 9, program-counter width; Cur_PC/Fetch_PC zero-extend to 32 bits
- BHT_DEPTH, 16, table entries; power of 2, ≥2; IDX_W = log2(BHT_DEPTH); IDX_W+2 ≤ PC_W
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- Fetch_PC  in  PC_W  PC being fetched
- Pred_Taken  out  1  fetch prediction
- Pred_Target  out  32  predicted next PC
- Valid_EX  in  1  execute-stage instruction valid
- Stall  in  1  freezes all state updates
- Cur_PC  in  PC_W  execute-stage PC
- Imm  in  32  immediate
- Branch, JalPrima, JalrSel, Halt  in  1 each  decode controls
- AluResult  in  32  bit0 = branch condition; JALR target
- Pred_Taken_EX  in  1  prediction carried with instruction
- Pred_Target_EX  in  32  predicted target carried with instruction
- PC_Imm, PC_Four  out  32  Cur_PC+Imm, Cur_PC+4 (mod 2^32)
- BrPC  out  32  redirect PC
- PcSel  out  1  1 = fetch takes BrPC
- Mispredict  out  1  redirect due to misprediction
- Halted  out  1  halt latched
- Br_Count, Mispred_Count  out  32 each  statistics

## Operation
- idx = PC[IDX_W+1:2]; tag = PC[PC_W-1:IDX_W+2] (0 bits allowed if IDX_W+2 = PC_W, then tag always matches).
- Per entry: cnt[1:0], valid, tag, target[31:0].
- Lookup (combinational on Fetch_PC): hit = valid && tag match. Pred_Taken = hit && cnt[1]. Pred_Target = Pred_Taken ? target : Fetch_PC+4.
- is_ctl = Branch || JalPrima || JalrSel.
- act_taken = (Branch && AluResult[0]) || JalPrima || JalrSel.
- act_target = JalrSel ? AluResult : PC_Imm (JalPrima/Branch have priority over JalrSel if both set).
- Mispredict = Valid_EX && !Halt && !Halted && (act_taken != Pred_Taken_EX || (act_taken && act_target != Pred_Target_EX)).
- BrPC priority: Halted → latched halt PC; Valid_EX && Halt → Cur_PC; Mispredict && act_taken → act_target; Mispredict → PC_Four; else 0.
- PcSel = Halted || (Valid_EX && Halt) || Mispredict.
- Update on edge when Valid_EX && is_ctl && !Stall && !Halted: cnt += act_taken ? 1 : −1 (saturate 0..3); if act_taken write valid=1, tag, target=act_target; not-taken leaves tag/target/valid.
- First allocation: taken instruction into an invalid or tag-mismatched entry sets cnt=2 (weakly taken), replacing the old entry.
- Halt FSM: RUN → HALTED when Valid_EX && Halt && !Stall, capturing Cur_PC; HALTED exits only on reset. In HALTED no table or counter updates.

## Timing
- Lookup and all resolve outputs are combinational; table writes visible from the next cycle.
- Same-cycle read/write of one entry: Fetch sees pre-write contents.
- Reset (any cycle, including mid-halt): all cnt=1, valid=0, tags/targets=0, FSM=RUN, Halted=0, latched PC=0, statistics=0. Resolve outputs then follow inputs combinationally.
- Stall=1: outputs still computed; no state changes.

## Configuration
- BRANCH_PREDICT_STATS_EN defined: Br_Count increments on each update event; Mispred_Count increments when that event also has Mispredict=1; both saturate at 32'hFFFF_FFFF.
- Undefined: both ports tied to 0; no counter registers.

## Test plan
- After reset, Fetch_PC=9'h010 → Pred_Taken=0, Pred_Target=32'h14; all counters read 1.
- Branch at Cur_PC=0x20, Imm=0x40, AluResult=1, Pred_Taken_EX=0 → Mispredict=1, PcSel=1, BrPC=0x60; next cycle Fetch_PC=0x20 gives Pred_Taken=1, Pred_Target=0x60.
- Same branch resolved not-taken twice → cnt 2→1→0; Pred_Taken=0 after first; second with Pred_Taken_EX=0 gives Mispredict=0, PcSel=0.
- JALR, AluResult=0x88, Pred_Taken_EX=1, Pred_Target_EX=0x84 → Mispredict=1, BrPC=0x88.
- Halt at Cur_PC=0x30 → PcSel=1, BrPC=0x30, Halted=1 held across later Branch inputs until reset; no table updates.
- With BRANCH_PREDICT_STATS_EN: 3 update events, 2 mispredicted → Br_Count=3, Mispred_Count=2; Stall=1 event not counted.
